// File: rtl/nukv_value_desegmenter.sv
// Strips the last flag from a framed value stream, forwards every word unchanged and
// checks the frame's word count against the length header carried in the first word.
module nukv_value_desegmenter #(
  parameter int MEMORY_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MEMORY_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [MEMORY_WIDTH-1:0] value_data,
  output logic                    value_valid,
  input  logic                    value_ready,
  output logic                    err_short,
  output logic                    err_long,
  output logic [15:0]             err_count
);

  typedef enum logic [1:0] {
    ST_HEADER = 2'd0,
    ST_BODY   = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Length is in 8-byte units; 17 bits keeps L=65535 from wrapping.
  function automatic logic [16:0] expected_words(input logic [15:0] len);
    logic [16:0] words;
    words = ({1'b0, len} + 17'd7) >> 3;
    if (words == 17'd0) begin
      expected_words = 17'd1;
    end else begin
      expected_words = words;
    end
  endfunction

  logic [MEMORY_WIDTH-1:0] main_data_r;
  logic [MEMORY_WIDTH-1:0] spare_data_r;
  logic                    main_valid_r;
  logic                    spare_valid_r;
  logic                    in_ready_r;
  state_t                  state_r;
  state_t                  state_next_s;
  logic [16:0]             exp_words_r;
  logic [16:0]             word_cnt_r;
  logic [16:0]             cnt_next_s;
  logic [16:0]             hdr_words_s;
  logic                    short_hit_s;
  logic                    long_hit_s;
  logic                    err_short_r;
  logic                    err_long_r;
  logic [15:0]             err_count_r;
  logic                    accept_s;
  logic                    deq_s;

  assign accept_s    = in_valid & in_ready_r;
  assign deq_s       = main_valid_r & value_ready;
  assign cnt_next_s  = word_cnt_r + 17'd1;
  assign hdr_words_s = expected_words(in_data[15:0]);

  assign in_ready    = in_ready_r;
  assign value_data  = main_data_r;
  assign value_valid = main_valid_r;
  assign err_short   = err_short_r;
  assign err_long    = err_long_r;
  assign err_count   = err_count_r;

  // Two-entry skid buffer: main entry drives the output, spare absorbs one stalled word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data_r   <= '0;
      spare_data_r  <= '0;
      main_valid_r  <= 1'b0;
      spare_valid_r <= 1'b0;
      in_ready_r    <= 1'b0;
    end else begin
      case ({main_valid_r, spare_valid_r})
        2'b00: begin
          in_ready_r <= 1'b1;
          if (accept_s) begin
            main_data_r  <= in_data;
            main_valid_r <= 1'b1;
          end
        end
        2'b10: begin
          if (accept_s && deq_s) begin
            main_data_r <= in_data;
          end else if (accept_s) begin
            spare_data_r  <= in_data;
            spare_valid_r <= 1'b1;
            in_ready_r    <= 1'b0;
          end else if (deq_s) begin
            main_valid_r <= 1'b0;
          end
        end
        2'b11: begin
          if (deq_s) begin
            main_data_r   <= spare_data_r;
            spare_valid_r <= 1'b0;
            in_ready_r    <= 1'b1;
          end
        end
        default: begin
          main_valid_r  <= 1'b0;
          spare_valid_r <= 1'b0;
          in_ready_r    <= 1'b1;
        end
      endcase
    end
  end

  // Frame tracking: next state and error detection for the word being accepted.
  always_comb begin
    state_next_s = state_r;
    short_hit_s  = 1'b0;
    long_hit_s   = 1'b0;
    if (accept_s) begin
      case (state_r)
        ST_HEADER: begin
          if (in_last) begin
            short_hit_s  = (hdr_words_s > 17'd1);
            state_next_s = ST_HEADER;
          end else if (hdr_words_s == 17'd1) begin
            long_hit_s   = 1'b1;
            state_next_s = ST_DRAIN;
          end else begin
            state_next_s = ST_BODY;
          end
        end
        ST_BODY: begin
          if (in_last) begin
            short_hit_s  = (cnt_next_s < exp_words_r);
            state_next_s = ST_HEADER;
          end else if (cnt_next_s == exp_words_r) begin
            long_hit_s   = 1'b1;
            state_next_s = ST_DRAIN;
          end else begin
            state_next_s = ST_BODY;
          end
        end
        ST_DRAIN: begin
          if (in_last) begin
            state_next_s = ST_HEADER;
          end else begin
            state_next_s = ST_DRAIN;
          end
        end
        default: begin
          state_next_s = ST_HEADER;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Frame state, word counters, registered error pulses and saturating error count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_HEADER;
      exp_words_r <= 17'd0;
      word_cnt_r  <= 17'd0;
      err_short_r <= 1'b0;
      err_long_r  <= 1'b0;
      err_count_r <= 16'd0;
    end else begin
      state_r     <= state_next_s;
      err_short_r <= short_hit_s;
      err_long_r  <= long_hit_s;
      if (accept_s && (state_r == ST_HEADER)) begin
        exp_words_r <= hdr_words_s;
        word_cnt_r  <= 17'd1;
      end else if (accept_s && (state_r == ST_BODY)) begin
        word_cnt_r  <= cnt_next_s;
      end else begin
        word_cnt_r  <= word_cnt_r;
      end
      if ((short_hit_s || long_hit_s) && (err_count_r != 16'hFFFF)) begin
        err_count_r <= err_count_r + 16'd1;
      end else begin
        err_count_r <= err_count_r;
      end
    end
  end

endmodule

// File: doc/nukv_value_desegmenter.md
# nukv_value_desegmenter

Receive-side counterpart of the value segmenter. It accepts a framed value stream of MEMORY_WIDTH-bit words, where the frame end is marked by a last flag and the first word carries the value length. It strips the last flag and re-emits the words as a plain value stream. While doing so it checks that the frame's word count matches the length header and reports short or long frames. It sits between the memory/network read path and the value consumers that expect header-prefixed, unframed values.

## Interface
Parameters:
- MEMORY_WIDTH, 512, data word width in bits. Must be a multiple of 64 and at least 64.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  MEMORY_WIDTH  framed input word.
- in_valid  in  1  in_data is valid.
- in_last  in  1  this word ends the frame.
- in_ready  out  1  block accepts a word this cycle.
- value_data  out  MEMORY_WIDTH  unframed output word.
- value_valid  out  1  value_data is valid.
- value_ready  in  1  downstream accepts.
- err_short  out  1  one-cycle pulse: frame ended before the expected word count.
- err_long  out  1  one-cycle pulse: frame exceeded the expected word count.
- err_count  out  16  saturating count of erroneous frames.

## Operation
- Transfers: input accepted when in_valid & in_ready; output transferred when value_valid & value_ready.
- Header decode:
  - The first accepted word of a frame is the header. L = in_data[15:0], in 8-byte units.
  - Expected words E = (L*8 <= 64) ? 1 : ceil(L*8/64), i.e. max(1, ceil(L/8)).
  - Compute in 17 bits, so L=65535 gives E=8192 with no overflow.
  - The header word is forwarded unmodified, including bits [15:0].
- State machine:
  - ST_HEADER (reset state): on accept, load exp_words=E and word_cnt=1.
    - If in_last=1: frame done. Stay in ST_HEADER; flag err_short if E>1.
    - If in_last=0 and E=1: pulse err_long, go to ST_DRAIN.
    - Otherwise go to ST_BODY.
  - ST_BODY: on accept, word_cnt+1.
    - If in_last=1: if word_cnt+1 < exp_words, pulse err_short. Go to ST_HEADER.
    - Else if word_cnt+1 == exp_words: pulse err_long, go to ST_DRAIN.
  - ST_DRAIN: forward words with no further error pulses. On accept with in_last=1, go to ST_HEADER.
- Pass-through: every accepted word is forwarded in order, including those of erroneous frames. None are dropped, padded or reordered.
- err_count: increments by 1 for each err_short or err_long pulse and saturates at 0xFFFF. At most one increment per frame.
- Buffering: a 2-entry skid buffer (output register plus one spare) gives one word per cycle throughput with in_ready registered.

## Timing
- Reset values:
  - value_valid=0, in_ready=0 while rst is asserted; in_ready=1 in the first cycle after rst deasserts.
  - err_short=0, err_long=0, err_count=0, state=ST_HEADER.
- Latency: a word accepted in cycle N is presented on value_data in cycle N+1 when the output is empty.
- in_ready=0 only when both skid entries are occupied.
- value_data and value_valid hold steady while value_valid=1 and value_ready=0.
- Error pulses are registered and asserted in the cycle after the offending word is accepted, for exactly 1 cycle.
- Back-to-back frames: a header may be accepted in the cycle after a last word, with no bubble.
- Simultaneous output dequeue and input accept with both entries full is not possible, since in_ready=0 in that state. With one entry full, both happen in the same cycle and occupancy stays at 1.
- Reset mid-frame:
  - In-flight words are discarded, counters cleared, state returns to ST_HEADER.
  - The next accepted word is treated as a header.

## Test plan
- Single-word frame: L=8, header with in_last=1 -> one output word identical to input, no error pulse, err_count=0.
- Multi-word frame: L=20 (E=3), 3 words with in_last on word 3, value_ready=1 -> 3 words out on consecutive cycles, latency 1, no error.
- Short frame: L=40 (E=5), in_last on word 2 -> 2 words forwarded, err_short pulses once, err_count=1. Next frame L=0, single word -> no error.
- Long frame: L=8 (E=1), 4 words with in_last on word 4 -> all 4 forwarded, err_long pulses once after word 1, err_count=1, back in ST_HEADER.
- Backpressure: L=64 (E=8), value_ready toggled in a 1-on/2-off pattern -> in_ready falls after 2 buffered words, output order and data intact, no loss or duplication.
- Reset mid-frame: async rst asserted during word 3 of an E=6 frame -> outputs at reset values immediately. A following L=16 frame yields 2 words, no error, err_count=0.
